// File: rtl/ioctl_sdram_packer.sv
// Packs the data_io download byte stream into 16-bit words, buffers them and drains them
// to the SDRAM ROM-load port over a toggle req/ack handshake. Optional: LOADER_CHECKSUM_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no request outstanding; issues the FIFO head when req==ack
// S_WAIT  | request toggled, holding addr/data/be until ack matches req
// S_FLUSH | download ended and last word queued; pulse done once drained
module ioctl_sdram_packer #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [24:0] BASE_ADDR  = 25'h0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [24:0] sdr_addr,
    output logic [15:0] sdr_data,
    output logic [1:0]  sdr_be,
    output logic        sdr_req,
    input  logic        sdr_ack,
    output logic        busy,
    output logic        done,
    output logic        overflow,
`ifdef LOADER_CHECKSUM_EN
    output logic [24:0] bytes_loaded,
    output logic [15:0] checksum
`else
    output logic [24:0] bytes_loaded
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_TH = CW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state, state_n;

    logic          downl_q;
    logic          fall_q;
    logic          flush_pend;
    logic          have_low;
    logic [7:0]    low_byte;
    logic          dl_rise;
    logic          dl_fall;
    logic          accept;

    logic          push;
    logic [17:0]   push_word;
    logic          push_ok;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [17:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          req_match;
    logic          done_n;
    logic          flush_clr;
    logic [23:0]   word_index;
    logic [24:0]   addr_sum;

    assign dl_rise    = ioctl_downl & ~downl_q;
    assign dl_fall    = ~ioctl_downl & downl_q;
    // A byte strobed on the cycle downl drops still belongs to the download.
    assign accept     = ioctl_wr & (ioctl_downl | downl_q);
    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign push_ok    = push & ~fifo_full;
    assign req_match  = (sdr_req == sdr_ack);
    assign addr_sum   = BASE_ADDR + {word_index, 1'b0};

    assign busy = ioctl_downl | ~fifo_empty | ~req_match | (state != S_IDLE)
                | fall_q | flush_pend;

    // The trailing-byte flush and a pair completion can never fall on the same cycle.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (fall_q && have_low) begin
            push      = 1'b1;
            push_word = {2'b01, 8'h00, low_byte};
        end else if (accept && have_low && !dl_rise) begin
            push      = 1'b1;
            push_word = {2'b11, ioctl_data, low_byte};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            downl_q      <= 1'b0;
            fall_q       <= 1'b0;
            flush_pend   <= 1'b0;
            have_low     <= 1'b0;
            low_byte     <= 8'h00;
            bytes_loaded <= '0;
            overflow     <= 1'b0;
        end else begin
            downl_q <= ioctl_downl;
            fall_q  <= dl_fall;
            if (dl_rise) begin
                bytes_loaded <= 25'(accept);
                overflow     <= 1'b0;
                have_low     <= accept;
                low_byte     <= ioctl_data;
            end else begin
                if (accept) begin
                    bytes_loaded <= bytes_loaded + 25'd1;
                    if (!have_low) begin
                        low_byte <= ioctl_data;
                        have_low <= 1'b1;
                    end else begin
                        have_low <= 1'b0;
                    end
                end
                if (fall_q) begin
                    have_low <= 1'b0;
                end
            end
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end
            if (fall_q) begin
                flush_pend <= 1'b1;
            end else if (flush_clr) begin
                flush_pend <= 1'b0;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            checksum <= 16'h0000;
        end else if (dl_rise) begin
            checksum <= accept ? {8'h00, ioctl_data} : 16'h0000;
        end else if (accept) begin
            checksum <= checksum + {8'h00, ioctl_data};
        end
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            ioctl_wait <= (count >= WAIT_TH);
        end
    end

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        done_n    = 1'b0;
        flush_clr = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && req_match) begin
                    pop     = 1'b1;
                    state_n = S_WAIT;
                end else if (flush_pend && req_match) begin
                    state_n = S_FLUSH;
                end
            end
            S_WAIT: begin
                if (req_match) begin
                    state_n = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (fifo_empty && req_match) begin
                    done_n    = 1'b1;
                    flush_clr = 1'b1;
                    state_n   = S_IDLE;
                end else if (!fifo_empty && req_match) begin
                    pop     = 1'b1;
                    state_n = S_WAIT;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Reset copies sdr_ack into sdr_req so an abandoned transfer leaves no request pending.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            sdr_req    <= sdr_ack;
            sdr_addr   <= BASE_ADDR;
            sdr_data   <= 16'h0000;
            sdr_be     <= 2'b00;
            word_index <= '0;
        end else begin
            state <= state_n;
            done  <= done_n;
            if (pop) begin
                sdr_req  <= ~sdr_req;
                sdr_be   <= fifo_mem[rd_ptr][17:16];
                sdr_data <= fifo_mem[rd_ptr][15:0];
                sdr_addr <= {addr_sum[24:1], 1'b0};
            end
            if (dl_rise) begin
                word_index <= '0;
            end else if (pop) begin
                word_index <= word_index + 24'd1;
            end
        end
    end

endmodule
